// File: rtl/rstn_sequencer_if.sv
// Control/status bundle of the reset sequencer: lock and software re-reset in,
// staged active-low resets and progress status out.
interface rstn_sequencer_if #(
    parameter int N_OUT = 4
);
    logic             lock;
    logic             sw_rst_req;
    logic [N_OUT-1:0] rstn_out;
    logic             seq_done;
    logic [1:0]       state_o;

    modport master (
        output lock,
        output sw_rst_req,
        input  rstn_out,
        input  seq_done,
        input  state_o
    );

    modport slave (
        input  lock,
        input  sw_rst_req,
        output rstn_out,
        output seq_done,
        output state_o
    );
endinterface

// File: rtl/rstn_sequencer.sv
// Staged reset_n generator: holds every domain in reset for a minimum time, waits for
// clock lock, then releases domains one by one in index order with a fixed gap.
module rstn_sequencer #(
    parameter int N_OUT           = 4,
    parameter int ASSERT_CYCLES   = 8,
    parameter int STAGE_CYCLES    = 4,
    parameter int LOCK_LOSS_RESET = 1
) (
    input  logic             clk,
    input  logic             reset,
    rstn_sequencer_if.slave  bus
);
    localparam int MAX_CYC = (ASSERT_CYCLES > STAGE_CYCLES) ? ASSERT_CYCLES : STAGE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int STG_W   = $clog2(N_OUT + 1);

    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STG_W-1:0] STAGE_FINAL = STG_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [STG_W-1:0] r_stage;
    logic [N_OUT-1:0] r_rstn_out;
    logic             r_seq_done;

    logic [N_OUT-1:0] w_stage_hit;
    logic             w_lock_lost;
    logic             w_restart;
    logic             w_stage_tick;

    // One-hot of the stage about to be released; OR-ing it in keeps release strictly in order.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_stage_hit
            assign w_stage_hit[gi] = (r_stage == STG_W'(gi));
        end
    endgenerate

    assign w_lock_lost  = (LOCK_LOSS_RESET != 0) && !bus.lock &&
                          ((r_state == ST_RELEASE) || (r_state == ST_DONE));
    assign w_restart    = bus.sw_rst_req || w_lock_lost;
    assign w_stage_tick = (r_cnt == STAGE_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_state    <= ST_ASSERT;
            r_cnt      <= '0;
            r_stage    <= '0;
            r_rstn_out <= '0;
            r_seq_done <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    r_rstn_out <= '0;
                    r_seq_done <= 1'b0;
                    if (r_cnt == ASSERT_LAST) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    if (bus.lock) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                        r_stage <= '0;
                    end
                end

                ST_RELEASE: begin
                    // Without lock (and no lock-loss restart) the count and stage simply freeze.
                    if (bus.lock) begin
                        if (w_stage_tick) begin
                            r_rstn_out <= r_rstn_out | w_stage_hit;
                            r_cnt      <= '0;
                            r_stage    <= r_stage + STG_W'(1);
                            if (r_stage == STAGE_FINAL) begin
                                r_state    <= ST_DONE;
                                r_seq_done <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    r_rstn_out <= '1;
                    r_seq_done <= 1'b1;
                end

                default: begin
                    r_state    <= ST_ASSERT;
                    r_cnt      <= '0;
                    r_stage    <= '0;
                    r_rstn_out <= '0;
                    r_seq_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rstn_out = r_rstn_out;
    assign bus.seq_done = r_seq_done;
    assign bus.state_o  = r_state;
endmodule

// File: tb/tb_rstn_sequencer.sv
// Scoreboard bench for three sequencer configurations sharing one stimulus stream,
// checked against a progress-count reference model.
module tb_rstn_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic lock;
    logic sw;

    rstn_sequencer_if #(.N_OUT(4)) if0 ();
    rstn_sequencer_if #(.N_OUT(4)) if1 ();
    rstn_sequencer_if #(.N_OUT(1)) if2 ();

    assign if0.lock = lock;  assign if0.sw_rst_req = sw;
    assign if1.lock = lock;  assign if1.sw_rst_req = sw;
    assign if2.lock = lock;  assign if2.sw_rst_req = sw;

    rstn_sequencer #(.N_OUT(4), .ASSERT_CYCLES(8), .STAGE_CYCLES(4), .LOCK_LOSS_RESET(1))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    rstn_sequencer #(.N_OUT(4), .ASSERT_CYCLES(8), .STAGE_CYCLES(4), .LOCK_LOSS_RESET(0))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    rstn_sequencer #(.N_OUT(1), .ASSERT_CYCLES(1), .STAGE_CYCLES(1), .LOCK_LOSS_RESET(1))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    // Model: edges spent holding, whether lock was accepted, qualifying release edges.
    typedef struct {
        int ae;
        bit st;
        int re;
    } mstate_t;

    typedef struct packed {
        int              cyc;
        logic [2:0][3:0] rstn;
        logic [2:0]      done;
        logic [2:0][1:0] st;
    } exp_t;

    exp_t    q[$];
    mstate_t ms[3];
    int      pa[3];
    int      ps[3];
    int      pn[3];
    bit      pl[3];
    int      cyc   = 0;
    int      total = 0;
    int      bad   = 0;

    function automatic mstate_t mnext(mstate_t s, int a, int st_c, int n, bit llr,
                                      bit r, bit swr, bit lk);
        mstate_t nx = s;
        if (r || swr || (llr && !lk && s.st)) begin
            nx.ae = 0; nx.st = 0; nx.re = 0;
        end else if (s.ae < a) begin
            nx.ae = s.ae + 1;
        end else if (!s.st) begin
            if (lk) nx.st = 1;
        end else if (s.re < n * st_c) begin
            if (lk) nx.re = s.re + 1;
        end
        return nx;
    endfunction

    function automatic int released(mstate_t s, int st_c, int n);
        int rel = s.re / st_c;
        if (rel > n) rel = n;
        return rel;
    endfunction

    task automatic step(input bit r, input bit swr, input bit lk);
        exp_t e;
        int   rel;
        reset = r; sw = swr; lock = lk;
        @(posedge clk);
        cyc++;
        e.cyc = cyc;
        for (int k = 0; k < 3; k++) begin
            ms[k] = mnext(ms[k], pa[k], ps[k], pn[k], pl[k], r, swr, lk);
            rel = released(ms[k], ps[k], pn[k]);
            e.rstn[k] = 4'((1 << rel) - 1);
            e.done[k] = (rel == pn[k]);
            if (ms[k].ae < pa[k])  e.st[k] = 2'd0;
            else if (!ms[k].st)    e.st[k] = 2'd1;
            else if (rel == pn[k]) e.st[k] = 2'd3;
            else                   e.st[k] = 2'd2;
        end
        q.push_back(e);
        #1;
    endtask

    // Monitor: outputs are registered every edge, so each negedge consumes one expectation.
    initial begin
        exp_t            e;
        logic [2:0][3:0] gr;
        logic [2:0]      gd;
        logic [2:0][1:0] gs;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                gr[0] = if0.rstn_out; gr[1] = if1.rstn_out; gr[2] = {3'b000, if2.rstn_out};
                gd[0] = if0.seq_done; gd[1] = if1.seq_done; gd[2] = if2.seq_done;
                gs[0] = if0.state_o;  gs[1] = if1.state_o;  gs[2] = if2.state_o;
                for (int k = 0; k < 3; k++) begin
                    total++;
                    if (gr[k] !== e.rstn[k]) begin
                        bad++;
                        $display("FAIL rstn_out edge=%0d dut%0d got=%b exp=%b", e.cyc, k, gr[k], e.rstn[k]);
                    end
                    total++;
                    if (gd[k] !== e.done[k]) begin
                        bad++;
                        $display("FAIL seq_done edge=%0d dut%0d got=%b exp=%b", e.cyc, k, gd[k], e.done[k]);
                    end
                    total++;
                    if (gs[k] !== e.st[k]) begin
                        bad++;
                        $display("FAIL state_o edge=%0d dut%0d got=%0d exp=%0d", e.cyc, k, gs[k], e.st[k]);
                    end
                end
                $display("edge=%0d in r=%b sw=%b lock=%b rstn0=%b rstn1=%b rstn2=%b", e.cyc,
                         reset, sw, lock, gr[0], gr[1], gr[2][0]);
            end
        end
    end

    initial begin
        pa = '{8, 8, 1}; ps = '{4, 4, 1}; pn = '{4, 4, 1}; pl = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) ms[k] = '{ae: 0, st: 0, re: 0};
        reset = 1'b1; sw = 1'b0; lock = 1'b1;

        // Nominal bring-up with lock held high
        repeat (3) step(1, 0, 1);
        repeat (30) step(0, 0, 1);
        // Single-cycle software re-reset from DONE
        step(0, 1, 1);
        repeat (30) step(0, 0, 1);
        // Lock absent at reset release, arrives later
        repeat (2) step(1, 0, 0);
        repeat (19) step(0, 0, 0);
        repeat (30) step(0, 0, 1);
        // Lock drop while two domains are released
        step(1, 0, 1);
        repeat (18) step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        repeat (25) step(0, 0, 1);
        // Reset and software request on the same edge mid-release
        step(1, 0, 1);
        repeat (15) step(0, 0, 1);
        step(1, 1, 1);
        repeat (30) step(0, 0, 1);
        // Software request held high
        repeat (12) step(0, 1, 1);
        repeat (30) step(0, 0, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 39) != 0);
        end

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
